encoder_period_filter: RTL and testbench

Conditions the raw motor encoder input and produces a cleaned, averaged edge-to-edge period in `clk` cycles for the PI speed loop. It sits between the encoder pin and the control loop's `period` input, replacing bare edge timing with a synchroniser, glitch filter, moving average and stall detection. When the motor stops, it reports the stall and a bounded "very slow" period, so the loop drives duty up instead of holding a stale value.

---
 rtl/encoder_period_filter.sv | 137 +++++++++++++
 tb/tb_encoder_period_filter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_period_filter.sv
// Encoder conditioning: synchroniser, glitch filter, edge period, stall detect.
// Define ENC_AVG_EN to build the moving-average history; otherwise raw samples.
module encoder_period_filter #(
  parameter int unsigned FILT_LEN     = 8,
  parameter int unsigned AVG_LOG2     = 2,
  parameter logic [31:0] TIMEOUT      = 32'd100000,
  parameter logic [31:0] RESET_PERIOD = 32'h072F1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        encoder,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        stalled,
  output logic [15:0] edge_count
);

  if (FILT_LEN < 1 || FILT_LEN > 255 || AVG_LOG2 > 4) begin : g_bad_cfg
    $error("encoder_period_filter: parameter out of range");
  end

  localparam logic [7:0] FILT_TOP = 8'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    RUN,
    STALL
  } state_t;

  state_t      state;
  logic        sync1;
  logic        sync2;
  logic        filt;
  logic [7:0]  stab_cnt;
  logic [31:0] ival;
  logic [31:0] new_period;
  logic        flip;
  logic        timeout_hit;
  logic        run_sample;
  logic        enter_stall;

  assign flip        = (sync2 != filt) && (stab_cnt == FILT_TOP);
  assign timeout_hit = (ival == TIMEOUT);
  assign run_sample  = flip && (state == RUN);
  assign enter_stall = timeout_hit && !flip && (state != STALL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt     <= 1'b0;
      stab_cnt <= 8'd0;
    end else begin
      sync1 <= encoder;
      sync2 <= sync1;
      if (sync2 == filt) begin
        stab_cnt <= 8'd0;
      end else if (flip) begin
        filt     <= ~filt;
        stab_cnt <= 8'd0;
      end else begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ival       <= 32'd1;
      edge_count <= 16'd0;
    end else begin
      if (flip) begin
        ival       <= 32'd1;
        edge_count <= edge_count + 16'd1;
      end else if (!timeout_hit) begin
        ival <= ival + 32'd1;
      end
    end
  end

`ifdef ENC_AVG_EN
  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = 32 + AVG_LOG2;

  logic [31:0]   hist [N];
  logic [PW-1:0] wr_ptr;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;

  // wr_ptr always addresses the oldest entry
  assign sum_next   = sum - SW'(hist[wr_ptr]) + SW'(ival);
  assign new_period = sum_next[AVG_LOG2 +: 32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) hist[i] <= RESET_PERIOD;
      sum    <= SW'(RESET_PERIOD) << AVG_LOG2;
      wr_ptr <= '0;
    end else if (run_sample) begin
      hist[wr_ptr] <= ival;
      sum          <= sum_next;
      wr_ptr       <= (wr_ptr == PW'(N - 1)) ? '0 : wr_ptr + 1'b1;
    end else if (enter_stall) begin
      for (int i = 0; i < N; i++) hist[i] <= TIMEOUT;
      sum <= SW'(TIMEOUT) << AVG_LOG2;
    end
  end
`else
  assign new_period = ival;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_FIRST;
      period       <= RESET_PERIOD;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (enter_stall) begin
        state        <= STALL;
        stalled      <= 1'b1;
        period       <= TIMEOUT;
        period_valid <= 1'b1;
      end else if (flip) begin
        state   <= RUN;
        stalled <= 1'b0;
        if (run_sample) begin
          period       <= new_period;
          period_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_period_filter.sv
// Bench for encoder_period_filter: randomized and directed encoder edges
// checked against an interval/average reference model.
module tb_encoder_period_filter;

  localparam int FL = 8;
  localparam int AL = 2;
  localparam int TO = 3000;
  localparam int RP = 'h72F1;
  localparam int N  = 1 << AL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        encoder = 1'b0;
  logic [31:0] period;
  logic        period_valid;
  logic        stalled;
  logic [15:0] edge_count;

  always #5 clk = ~clk;

  encoder_period_filter #(
    .FILT_LEN(FL),
    .AVG_LOG2(AL),
    .TIMEOUT(32'(TO)),
    .RESET_PERIOD(32'(RP))
  ) dut (
    .clk(clk),
    .reset(reset),
    .encoder(encoder),
    .period(period),
    .period_valid(period_valid),
    .stalled(stalled),
    .edge_count(edge_count)
  );

  int     checks = 0;
  int     errors = 0;
  int     obs[$];
  int     expq[$];
  int     hist[$];
  int     m_state;
  int     m_edges;
  longint now_c = 0;
  longint last_t = 0;

  always @(negedge clk) if (!reset && period_valid) obs.push_back(int'(period));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 = waiting for first edge, 1 = running, 2 = stalled
  function automatic void m_reset();
    m_state = 0;
    m_edges = 0;
    hist.delete();
    for (int i = 0; i < N; i++) hist.push_back(RP);
    last_t = now_c;
  endfunction

  function automatic void m_idle();
    if (m_state != 2 && now_c - last_t > TO) begin
      m_state = 2;
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back(TO);
      expq.push_back(TO);
    end
  endfunction

  function automatic void m_edge();
    int     s;
    longint sum;
    m_idle();
    m_edges++;
    if (m_state == 1) begin
      s = int'(now_c - last_t);
`ifdef ENC_AVG_EN
      hist.push_back(s);
      void'(hist.pop_front());
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      expq.push_back(int'(sum / N));
`else
      sum = s;
      expq.push_back(int'(sum));
`endif
    end
    m_state = 1;
    last_t = now_c;
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      now_c++;
    end
  endtask

  task automatic checkpoint();
    longint el;
    int     n;
    el = now_c - last_t;
    if (m_state != 2 && el > TO && el <= TO + FL + 8) return;
    m_idle();
    check("pulse_count", obs.size(), expq.size());
    n = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < n; i++) check("period", obs[i], expq[i]);
    obs.delete();
    expq.delete();
    check("edge_count", edge_count, 16'(m_edges));
    check("stalled", stalled, m_state == 2);
  endtask

  task automatic hold(int n);
    encoder = ~encoder;
    m_edge();
    tick(n);
    checkpoint();
  endtask

  task automatic glitch(int w, int rest);
    encoder = ~encoder;
    if (w >= FL) m_edge();
    tick(w);
    encoder = ~encoder;
    if (w >= FL) m_edge();
    tick(rest);
    checkpoint();
  endtask

  int step_exp[4];
  int w;

  initial begin
`ifdef ENC_AVG_EN
    step_exp = '{1750, 1500, 1250, 1000};
`else
    step_exp = '{1000, 1000, 1000, 1000};
`endif
    tick(3);
    check("rst_period", period, RP);
    check("rst_valid", period_valid, 1'b0);
    check("rst_stalled", stalled, 1'b0);
    check("rst_edges", edge_count, 16'd0);
    reset = 1'b0;
    m_reset();

    tick(TO + 200);
    checkpoint();
    hold(500);
    repeat (4) hold(1700);

    repeat (5) hold(2000);
    for (int i = 0; i < 5; i++) begin
      hold(1000);
      if (i > 0) check("step", period, step_exp[i-1]);
    end

    glitch(5, 100);
    glitch(9, 100);

    hold(TO);
    hold(500);
    hold(TO + 1);
    hold(500);
    hold(500);

    hold(TO + 500);
    hold(600);
    hold(700);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom_range(0, 1) ? $urandom_range(1, FL - 2)
                                 : $urandom_range(FL + 1, 20);
        glitch(w, $urandom_range(FL + 10, 300));
      end else begin
        hold($urandom_range(FL + 10, TO));
      end
    end

    tick(5);
    reset = 1'b1;
    encoder = 1'b0;
    #2;
    check("mid_rst_period", period, RP);
    check("mid_rst_stalled", stalled, 1'b0);
    check("mid_rst_valid", period_valid, 1'b0);
    check("mid_rst_edges", edge_count, 16'd0);
    tick(3);
    reset = 1'b0;
    obs.delete();
    expq.delete();
    m_reset();
    hold(800);
    hold(900);
    tick(20);
    checkpoint();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
